// File: rtl/hdmi_cmd_ctrl.sv
// hdmi_cmd_ctrl: UART command processor for the HDMI tester.
// Decodes single-byte commands and, depending on the command, loads the EDID RAM,
// drives HPD, or runs a gated frequency measurement on one of NUM_CH counter
// channels. Every reply goes out as uppercase hex followed by CR LF.
// Optional feature macro: EDID_READBACK_EN adds the 'R' command, which streams
// back the whole EDID RAM.
module hdmi_cmd_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int CTR_W       = 28,
    parameter int GATE_CYCLES = 50000000,
    parameter int EDID_AW     = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_strobe,
    input  logic [7:0]              rx_data,
    input  logic                    rx_break,
    output logic                    tx_load,
    output logic [7:0]              tx_data,
    input  logic                    tx_idle,
    output logic                    edid_we,
    output logic [EDID_AW-1:0]      edid_waddr,
    output logic [7:0]              edid_wdata,
    output logic [EDID_AW-1:0]      edid_raddr,
    input  logic [7:0]              edid_rdata,
    output logic                    hpd,
    input  logic [NUM_CH-1:0]       locked,
    output logic [NUM_CH-1:0]       ctr_req,
    input  logic [NUM_CH-1:0]       ctr_ack,
    input  logic [NUM_CH*CTR_W-1:0] ctr_val
);
    // Reply digits are kept top-aligned in a shift register that is wide enough
    // for either a full counter value or one EDID byte.
    localparam int NIB  = (CTR_W + 3) / 4;
    localparam int VW   = (NIB * 4 > 8) ? NIB * 4 : 8;
    localparam int SH   = VW - NIB * 4;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GW   = $clog2(GATE_CYCLES + 1);

    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [7:0]    NUM_CH_B  = 8'(NUM_CH);
    localparam logic [3:0]    NIB_C     = 4'(NIB);
    localparam logic [VW-1:0] ALL_F     = {VW{1'b1}} << SH;

    typedef enum logic [3:0] {
        WAIT_BREAK, WAIT_CMD, WAIT_CH, MEAS_TIME, MEAS_RES,
        EDID, HPD, RB, SEND_VAL, SEND_CR, SEND_LF
    } state_t;

    state_t               state_q, state_d;
    logic                 tx_load_q, tx_load_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 edid_we_q, edid_we_d;
    logic [EDID_AW-1:0]   edid_waddr_q, edid_waddr_d;
    logic [7:0]           edid_wdata_q, edid_wdata_d;
    logic                 hpd_q, hpd_d;
    logic [NUM_CH-1:0]    ctr_req_q, ctr_req_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [GW-1:0]        gate_q, gate_d;
    logic [VW-1:0]        val_q, val_d;
    logic [3:0]           dig_q, dig_d;
`ifdef EDID_READBACK_EN
    logic [EDID_AW-1:0]   edid_raddr_q, edid_raddr_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 rb_q, rb_d;
    logic [1:0]           rb_wait_q, rb_wait_d;
    logic                 rb_done_q, rb_done_d;
`else
    logic                 unused_rdata;
    assign unused_rdata = ^edid_rdata;
`endif

    logic [CTR_W-1:0]     val_arr [NUM_CH];
    logic [7:0]           ch_off;
    logic                 ch_ok;
    logic [CH_W-1:0]      ch_sel;
    logic                 can_load;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_val
        assign val_arr[i] = ctr_val[i*CTR_W +: CTR_W];
    end

    assign ch_off   = rx_data - 8'h30;
    assign ch_ok    = (rx_data >= 8'h30) && (ch_off < NUM_CH_B);
    assign ch_sel   = ch_off[CH_W-1:0];
    // A new load needs an idle transmitter and no load in the previous cycle.
    assign can_load = tx_idle && !tx_load_q;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Next-state and output computation for the command FSM.
    always_comb begin
        state_d      = state_q;
        tx_load_d    = 1'b0;
        tx_data_d    = tx_data_q;
        edid_we_d    = 1'b0;
        edid_waddr_d = edid_we_q ? edid_waddr_q + EDID_AW'(1) : edid_waddr_q;
        edid_wdata_d = edid_wdata_q;
        hpd_d        = hpd_q;
        ctr_req_d    = ctr_req_q;
        ch_d         = ch_q;
        gate_d       = gate_q;
        val_d        = val_q;
        dig_d        = dig_q;
`ifdef EDID_READBACK_EN
        edid_raddr_d = edid_raddr_q;
        rdata_d      = edid_rdata;
        rb_d         = rb_q;
        rb_wait_d    = rb_wait_q;
        rb_done_d    = rb_done_q;
`endif
        if (rx_break) begin
            // Break wins over everything; a registered tx_load still completes.
            state_d = WAIT_CMD;
`ifdef EDID_READBACK_EN
            rb_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                WAIT_BREAK: ;
                WAIT_CMD: begin
                    if (rx_strobe) begin
                        case (rx_data)
                            8'h43: state_d = WAIT_CH;
                            8'h45: begin
                                state_d      = EDID;
                                edid_waddr_d = '0;
                            end
                            8'h48: state_d = HPD;
`ifdef EDID_READBACK_EN
                            8'h52: begin
                                state_d      = RB;
                                edid_raddr_d = '0;
                                rb_d         = 1'b1;
                                rb_wait_d    = 2'd0;
                                rb_done_d    = 1'b0;
                            end
`endif
                            default: state_d = WAIT_BREAK;
                        endcase
                    end
                end
                WAIT_CH: begin
                    if (rx_strobe) begin
                        if (ch_ok && locked[ch_sel]) begin
                            ch_d              = ch_sel;
                            ctr_req_d[ch_sel] = ~ctr_req_q[ch_sel];
                            gate_d            = GATE_LOAD;
                            state_d           = MEAS_TIME;
                        end else begin
                            val_d   = ALL_F;
                            dig_d   = NIB_C;
                            state_d = SEND_VAL;
                        end
                    end
                end
                MEAS_TIME: begin
                    if (!locked[ch_q]) begin
                        val_d   = ALL_F;
                        dig_d   = NIB_C;
                        state_d = SEND_VAL;
                    end else if (gate_q == '0) begin
                        ctr_req_d[ch_q] = ~ctr_req_q[ch_q];
                        state_d         = MEAS_RES;
                    end else begin
                        gate_d = gate_q - GW'(1);
                    end
                end
                MEAS_RES: begin
                    if (!locked[ch_q]) begin
                        val_d   = ALL_F;
                        dig_d   = NIB_C;
                        state_d = SEND_VAL;
                    end else if (ctr_req_q[ch_q] == ctr_ack[ch_q]) begin
                        val_d   = VW'(val_arr[ch_q]) << SH;
                        dig_d   = NIB_C;
                        state_d = SEND_VAL;
                    end
                end
                EDID: begin
                    // The write to the last address has just happened: reply "0".
                    if (edid_we_q && (edid_waddr_q == '1)) begin
                        val_d   = '0;
                        dig_d   = 4'd1;
                        state_d = SEND_VAL;
                    end else if (rx_strobe) begin
                        edid_we_d    = 1'b1;
                        edid_wdata_d = rx_data;
                    end
                end
                HPD: begin
                    if (rx_strobe) begin
                        hpd_d   = rx_data[0];
                        val_d   = '0;
                        dig_d   = 4'd1;
                        state_d = SEND_VAL;
                    end
                end
`ifdef EDID_READBACK_EN
                RB: begin
                    // Wait out RAM latency plus the capture register, then queue a byte.
                    if (rb_wait_q != 2'd2) begin
                        rb_wait_d = rb_wait_q + 2'd1;
                    end else begin
                        val_d        = VW'(rdata_q) << (VW - 8);
                        dig_d        = 4'd2;
                        rb_done_d    = (edid_raddr_q == '1);
                        edid_raddr_d = edid_raddr_q + EDID_AW'(1);
                        state_d      = SEND_VAL;
                    end
                end
`endif
                SEND_VAL: begin
                    if (can_load) begin
                        tx_load_d = 1'b1;
                        tx_data_d = hex_char(val_q[VW-1 -: 4]);
                        val_d     = val_q << 4;
                        dig_d     = dig_q - 4'd1;
                        if (dig_q == 4'd1) begin
`ifdef EDID_READBACK_EN
                            if (rb_q && !rb_done_q) begin
                                state_d   = RB;
                                rb_wait_d = 2'd0;
                            end else begin
                                state_d = SEND_CR;
                            end
`else
                            state_d = SEND_CR;
`endif
                        end
                    end
                end
                SEND_CR: begin
                    if (can_load) begin
                        tx_load_d = 1'b1;
                        tx_data_d = 8'h0D;
                        state_d   = SEND_LF;
                    end
                end
                SEND_LF: begin
                    if (can_load) begin
                        tx_load_d = 1'b1;
                        tx_data_d = 8'h0A;
                        state_d   = WAIT_CMD;
`ifdef EDID_READBACK_EN
                        rb_d      = 1'b0;
`endif
                    end
                end
                default: state_d = WAIT_BREAK;
            endcase
        end
    end

    // State and registered outputs, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_BREAK;
            tx_load_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            edid_we_q    <= 1'b0;
            edid_waddr_q <= '0;
            edid_wdata_q <= 8'h00;
            hpd_q        <= 1'b0;
            ctr_req_q    <= '0;
            ch_q         <= '0;
            gate_q       <= '0;
            val_q        <= '0;
            dig_q        <= 4'd0;
`ifdef EDID_READBACK_EN
            edid_raddr_q <= '0;
            rdata_q      <= 8'h00;
            rb_q         <= 1'b0;
            rb_wait_q    <= 2'd0;
            rb_done_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tx_load_q    <= tx_load_d;
            tx_data_q    <= tx_data_d;
            edid_we_q    <= edid_we_d;
            edid_waddr_q <= edid_waddr_d;
            edid_wdata_q <= edid_wdata_d;
            hpd_q        <= hpd_d;
            ctr_req_q    <= ctr_req_d;
            ch_q         <= ch_d;
            gate_q       <= gate_d;
            val_q        <= val_d;
            dig_q        <= dig_d;
`ifdef EDID_READBACK_EN
            edid_raddr_q <= edid_raddr_d;
            rdata_q      <= rdata_d;
            rb_q         <= rb_d;
            rb_wait_q    <= rb_wait_d;
            rb_done_q    <= rb_done_d;
`endif
        end
    end

    assign tx_load    = tx_load_q;
    assign tx_data    = tx_data_q;
    assign edid_we    = edid_we_q;
    assign edid_waddr = edid_waddr_q;
    assign edid_wdata = edid_wdata_q;
    assign hpd        = hpd_q;
    assign ctr_req    = ctr_req_q;
`ifdef EDID_READBACK_EN
    assign edid_raddr = edid_raddr_q;
`else
    assign edid_raddr = '0;
`endif

endmodule
